// File: rtl/btn_conditioner_if.sv
// Push-button bundle between the raw board pins and the conditioned outputs.
interface btn_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] repeat_en;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_repeat;

    modport master (
        output btn_raw,
        output repeat_en,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_repeat
    );

    modport slave (
        input  btn_raw,
        input  repeat_en,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_repeat
    );
endinterface

// File: rtl/btn_conditioner.sv
// Per-button synchroniser, debouncer, press/release edge pulses and hold-to-autorepeat.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic              clk,
    input  logic              reset,
    btn_conditioner_if.slave  bus
);
    localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCW  = $clog2(RMAX + 1);

    localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DLY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RATE_LAST = RCW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

    logic [N_BTN-1:0] meta_q, sync_q;
    logic [N_BTN-1:0] deb_q, deb_d;
    logic [DCW-1:0]   cnt_q [N_BTN];
    logic [DCW-1:0]   cnt_d [N_BTN];
    logic [N_BTN-1:0] level_q, press_q, release_q, repeat_q;
    logic [N_BTN-1:0] press_d, release_d, repeat_d;
    rpt_state_e       state_q [N_BTN];
    rpt_state_e       state_d [N_BTN];
    logic [RCW-1:0]   rcnt_q [N_BTN];
    logic [RCW-1:0]   rcnt_d [N_BTN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q    <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= IDLE;
                rcnt_q[i]  <= '0;
            end
        end else begin
            meta_q    <= bus.btn_raw;
            sync_q    <= meta_q;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            level_q   <= deb_q;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
        end
    end

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    assign press_d   = deb_q & ~level_q;
    assign release_d = ~deb_q & level_q;

    // Release/disable is tested against the level about to be presented, so no
    // repeat pulse can ever share a cycle with btn_level low.
    always_comb begin
        repeat_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            case (state_q[i])
                IDLE: begin
                    repeat_d[i] = press_d[i];
                    if (press_d[i] && bus.repeat_en[i]) begin
                        state_d[i] = DELAY;
                        rcnt_d[i]  = '0;
                    end
                end
                DELAY, REPEAT: begin
                    if (!deb_q[i] || !bus.repeat_en[i]) begin
                        state_d[i] = IDLE;
                        rcnt_d[i]  = '0;
                    end else if (rcnt_q[i] == ((state_q[i] == DELAY) ? DLY_LAST : RATE_LAST)) begin
                        repeat_d[i] = 1'b1;
                        state_d[i]  = REPEAT;
                        rcnt_d[i]   = '0;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RCW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    rcnt_d[i]  = '0;
                end
            endcase
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.btn_repeat  = repeat_q;
endmodule
